// File: rtl/shipment_pkg.sv
// Shared types and defaults for the shipment sequencer slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Ports: none. Provides state_t, the STAGE_CYCLES/CUSTOMS_TIMEOUT defaults and the timer width.
package shipment_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CUSTOMS,
    STAGING,
    TRANSIT,
    ARRIVED,
    REJECT
  } state_t;

  localparam int STAGE_CYCLES_DEF    = 4;
  localparam int CUSTOMS_TIMEOUT_DEF = 16;
  localparam int TIMER_W             = 8;

endpackage

// File: rtl/shipment_sequencer_if.sv
// Bundles the parcel handshake, customs/truck/delivery events and status outputs.
// Latency: n/a (wiring only).
// Backpressure: parcel_valid/parcel_ready handshake; events are single-cycle pulses.
// Modports: master = upstream/environment side, slave = sequencer side.
interface shipment_sequencer_if #(
  parameter int COUNT_W = 16
);
  logic               parcel_valid;
  logic [7:0]         parcel_id;
  logic               parcel_ready;
  logic               inspect_pass;
  logic               inspect_fail;
  logic               truck_slot;
  logic               truck_arrived;
  logic               delivery_confirmed;
  logic               customs_cleared;
  logic               transit_ready;
  logic               arrived_on_truck;
  logic [7:0]         active_id;
  logic               rejected;
  logic [COUNT_W-1:0] delivered_count;

  modport master (
    output parcel_valid, parcel_id, inspect_pass, inspect_fail,
           truck_slot, truck_arrived, delivery_confirmed,
    input  parcel_ready, customs_cleared, transit_ready, arrived_on_truck,
           active_id, rejected, delivered_count
  );

  modport slave (
    input  parcel_valid, parcel_id, inspect_pass, inspect_fail,
           truck_slot, truck_arrived, delivery_confirmed,
    output parcel_ready, customs_cleared, transit_ready, arrived_on_truck,
           active_id, rejected, delivered_count
  );
endinterface

// File: rtl/shipment_timer.sv
// Loadable 8-bit down-counter with terminal-count flag; holds at zero.
// Latency: value updates on the edge after load/en; tc is combinational from the register.
// Backpressure: none; load has priority over enable.
// Ports: clk, rst (async high), load, load_val, en in; tc out (value == 0).
module shipment_timer
  import shipment_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               en,
  output logic               tc
);

  logic [TIMER_W-1:0] value;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (en && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

  assign tc = (value == '0);

endmodule

// File: rtl/shipment_sequencer.sv
// Walks one parcel at a time through customs, staging, transit and delivery confirmation.
// Latency: accept-to-IDLE minimum 5 cycles (STAGE_CYCLES=1, immediate responses); all outputs registered.
// Backpressure: parcel_ready is high only in IDLE; a single parcel is in flight at a time.
// Ports: clk, rst (async high), bus (shipment_sequencer_if.slave).
// Build option: define SHIPMENT_TIMEOUT_EN to auto-reject after CUSTOMS_TIMEOUT cycles in customs.
module shipment_sequencer
  import shipment_pkg::*;
#(
  parameter int STAGE_CYCLES    = STAGE_CYCLES_DEF,
  parameter int CUSTOMS_TIMEOUT = CUSTOMS_TIMEOUT_DEF,
  parameter int COUNT_W         = 16
)(
  input  logic                 clk,
  input  logic                 rst,
  shipment_sequencer_if.slave  bus
);

  if (STAGE_CYCLES < 1 || STAGE_CYCLES > 255) begin : g_stage_range
    $error("STAGE_CYCLES out of range 1..255");
  end
  if (CUSTOMS_TIMEOUT < 1 || CUSTOMS_TIMEOUT > 255) begin : g_timeout_range
    $error("CUSTOMS_TIMEOUT out of range 1..255");
  end

  // Timer counts down from N-1, so tc marks the N-th cycle in the state.
  localparam logic [TIMER_W-1:0] STAGE_LOAD = TIMER_W'(STAGE_CYCLES - 1);
`ifdef SHIPMENT_TIMEOUT_EN
  localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(CUSTOMS_TIMEOUT - 1);
`endif

  state_t             state;
  logic               ready_q;
  logic               cleared_q;
  logic               transit_q;
  logic               arrived_q;
  logic               rejected_q;
  logic [7:0]         id_q;
  logic [COUNT_W-1:0] count_q;

  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_en;
  logic               tmr_tc;

  // One timer serves both phases: reloaded on customs entry (timeout build)
  // and again on the pass edge for staging.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = STAGE_LOAD;
    tmr_en   = 1'b0;
    case (state)
`ifdef SHIPMENT_TIMEOUT_EN
      IDLE: begin
        if (bus.parcel_valid && ready_q) begin
          tmr_load = 1'b1;
          tmr_val  = TIMEOUT_LOAD;
        end
      end
`endif
      CUSTOMS: begin
        if (bus.inspect_pass && !bus.inspect_fail) begin
          tmr_load = 1'b1;
          tmr_val  = STAGE_LOAD;
        end
`ifdef SHIPMENT_TIMEOUT_EN
        else begin
          tmr_en = 1'b1;
        end
`endif
      end
      STAGING: tmr_en = 1'b1;
      default: ;
    endcase
  end

  shipment_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .tc       (tmr_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ready_q    <= 1'b1;
      cleared_q  <= 1'b0;
      transit_q  <= 1'b0;
      arrived_q  <= 1'b0;
      rejected_q <= 1'b0;
      id_q       <= '0;
      count_q    <= '0;
    end else begin
      rejected_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.parcel_valid && ready_q) begin
            id_q    <= bus.parcel_id;
            ready_q <= 1'b0;
            state   <= CUSTOMS;
          end
        end
        CUSTOMS: begin
          // Fail outranks pass; either outranks the timeout on the same cycle.
          if (bus.inspect_fail) begin
            rejected_q <= 1'b1;
            state      <= REJECT;
          end else if (bus.inspect_pass) begin
            cleared_q <= 1'b1;
            state     <= STAGING;
          end
`ifdef SHIPMENT_TIMEOUT_EN
          else if (tmr_tc) begin
            rejected_q <= 1'b1;
            state      <= REJECT;
          end
`endif
        end
        STAGING: begin
          if (tmr_tc && bus.truck_slot) begin
            transit_q <= 1'b1;
            state     <= TRANSIT;
          end
        end
        TRANSIT: begin
          if (bus.truck_arrived) begin
            arrived_q <= 1'b1;
            state     <= ARRIVED;
          end
        end
        ARRIVED: begin
          if (bus.delivery_confirmed) begin
            if (count_q != '1) begin
              count_q <= count_q + 1'b1;
            end
            cleared_q <= 1'b0;
            transit_q <= 1'b0;
            arrived_q <= 1'b0;
            ready_q   <= 1'b1;
            state     <= IDLE;
          end
        end
        REJECT: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.parcel_ready     = ready_q;
  assign bus.customs_cleared  = cleared_q;
  assign bus.transit_ready    = transit_q;
  assign bus.arrived_on_truck = arrived_q;
  assign bus.active_id        = id_q;
  assign bus.rejected         = rejected_q;
  assign bus.delivered_count  = count_q;

endmodule
